// File: rtl/bitseq_multi.sv
// bitseq_multi: multi-channel step sequencer.
// A shared divider produces step events. One step pointer walks the pattern
// in forward, reverse, ping-pong or random order. Each channel gets a
// one-cycle trigger and a gate of programmable width.
// Optional feature: define BITSEQ_MULTI_RANDOM_EN to build the LFSR and
// random mode. Without it, mode 2'b11 plays forward.
module bitseq_multi #(
    parameter int CHANNELS = 4,
    parameter int STEPS    = 16,
    parameter int DIV_W    = 24,
    localparam int SW      = $clog2(STEPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      restart,
    input  logic [DIV_W-1:0]          div,
    input  logic [SW-1:0]             len,
    input  logic [1:0]                mode,
    input  logic [DIV_W-1:0]          gate_len,
    input  logic [CHANNELS*STEPS-1:0] pattern,
    output logic                      tick,
    output logic [SW-1:0]             step,
    output logic [CHANNELS-1:0]       trig,
    output logic [CHANNELS-1:0]       gate
);

    typedef enum logic [1:0] {
        MODE_FWD  = 2'b00,
        MODE_REV  = 2'b01,
        MODE_PING = 2'b10,
        MODE_RND  = 2'b11
    } mode_e;

    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    gate_cnt;
    logic                dir_up;
    logic                primed;
    logic [DIV_W-1:0]    div_last;
    logic [SW-1:0]       nxt_step;
    logic                nxt_up;
    logic [CHANNELS-1:0] pat_bits;

    // A divide value of 0 behaves like 1: an event on every cycle.
    assign div_last = (div == '0) ? '0 : div - DIV_W'(1);

`ifdef BITSEQ_MULTI_RANDOM_EN
    logic [15:0]   lfsr;
    logic [SW-1:0] len_mask;
    logic [SW-1:0] cand;
    logic [SW-1:0] rnd_step;

    // Free-running LFSR, x^16+x^14+x^13+x^11+1; keeps running while ena is low.
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge; = here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Fold the LFSR into 0..len: mask to the bit length of len, then fold
    // the overshoot back down. Assumes SW <= 16.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < SW; i++) begin
            len_mask = len_mask | (len >> i);
        end
        cand     = lfsr[SW-1:0] & len_mask;
        rnd_step = (cand > len) ? cand - len - SW'(1) : cand;
    end
`endif

    // Choose the step (and ping-pong direction) that the next event loads.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_step = '0;
        nxt_up   = dir_up;
        if (!primed) begin
            case (mode_e'(mode))
                MODE_REV: begin
                    if (step > len || step == '0) nxt_step = len;
                    else                          nxt_step = step - SW'(1);
                end
                MODE_PING: begin
                    if (len == '0 || step > len) begin
                        nxt_step = '0;
                        nxt_up   = 1'b1;
                    end else if (dir_up) begin
                        if (step == len) begin
                            nxt_step = step - SW'(1);
                            nxt_up   = 1'b0;
                        end else begin
                            nxt_step = step + SW'(1);
                        end
                    end else begin
                        if (step == '0) begin
                            nxt_step = SW'(1);
                            nxt_up   = 1'b1;
                        end else begin
                            nxt_step = step - SW'(1);
                        end
                    end
                end
`ifdef BITSEQ_MULTI_RANDOM_EN
                MODE_RND: nxt_step = rnd_step;
`endif
                default: nxt_step = (step >= len) ? '0 : step + SW'(1);
            endcase
        end
    end

    // Pattern bit of the step about to be played, one per channel.
    always_comb begin
        pat_bits = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            pat_bits[ch] = pattern[ch*STEPS + int'(nxt_step)];
        end
    end

    // Divider, step pointer, triggers and gate timing. Restart overrides a
    // coincident step event; ena low freezes everything except tick/trig.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            gate_cnt <= '0;
            step     <= '0;
            tick     <= 1'b0;
            trig     <= '0;
            gate     <= '0;
            dir_up   <= 1'b1;
            primed   <= 1'b1;
        end else if (restart) begin
            div_cnt  <= '0;
            gate_cnt <= '0;
            tick     <= 1'b0;
            trig     <= '0;
            gate     <= '0;
            dir_up   <= 1'b1;
            primed   <= 1'b1;
        end else if (!ena) begin
            tick <= 1'b0;
            trig <= '0;
        end else if (div_cnt == div_last) begin
            div_cnt  <= '0;
            step     <= nxt_step;
            dir_up   <= nxt_up;
            primed   <= 1'b0;
            tick     <= 1'b1;
            trig     <= pat_bits;
            gate     <= (gate_len != '0) ? pat_bits : '0;
            gate_cnt <= DIV_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= 1'b0;
            trig    <= '0;
            // Gate counter saturates at gate_len; once there the gates drop.
            // If gate_len >= div the next event reloads it first (legato).
            if (gate_cnt >= gate_len) gate     <= '0;
            else                      gate_cnt <= gate_cnt + DIV_W'(1);
        end
    end

endmodule

// File: tb/tb_bitseq_multi.sv
// Testbench for bitseq_multi: directed phases with a scoreboard. Stimulus
// pushes the expected step/trig/gate/spacing of each event; a monitor pops
// and compares whenever tick is high.
module tb_bitseq_multi;

    localparam int CH    = 4;
    localparam int STEPS = 16;
    localparam int DIV_W = 24;
    localparam int SW    = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ena;
    logic                   restart;
    logic [DIV_W-1:0]       div;
    logic [SW-1:0]          len;
    logic [1:0]             mode;
    logic [DIV_W-1:0]       gate_len;
    logic [CH*STEPS-1:0]    pattern;
    logic                   tick;
    logic [SW-1:0]          step;
    logic [CH-1:0]          trig;
    logic [CH-1:0]          gate;

    bitseq_multi #(.CHANNELS(CH), .STEPS(STEPS), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .restart  (restart),
        .div      (div),
        .len      (len),
        .mode     (mode),
        .gate_len (gate_len),
        .pattern  (pattern),
        .tick     (tick),
        .step     (step),
        .trig     (trig),
        .gate     (gate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SW-1:0] step;   // expected step, or upper bound when rnd
        logic [CH-1:0] trig;
        logic [CH-1:0] gate;
        int            gap;    // expected cycles since previous tick, 0 = skip
        bit            rnd;
    } exp_t;

    exp_t exp_q[$];
    int   gw_q[$];
    exp_t me;

    int total = 0;
    int bad   = 0;
    int cyc = 0;
    int last_cyc = 0;
    int tick_seen = 0;
    int gw_run = 0;
    bit gw_en = 0;
    bit leg_en = 0;
    int leg_low = 0;
    int hist[16];
    int saved_ticks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] pat_at(input logic [CH*STEPS-1:0] p, input int s);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = p[c*STEPS + s];
        return r;
    endfunction

    task automatic push_step(input int s, input int gap);
        exp_t e;
        e.step = SW'(s);
        e.trig = pat_at(pattern, s);
        e.gate = (gate_len != 0) ? e.trig : '0;
        e.gap  = gap;
        e.rnd  = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_rnd(input int bound);
        exp_t e;
        e.step = SW'(bound);
        e.trig = '0;
        e.gate = '0;
        e.gap  = 1;
        e.rnd  = 1;
        exp_q.push_back(e);
    endtask

    // Wait until at most 'left' events remain and no gate width is pending.
    task automatic wait_q(input int left, input int budget);
        int n = 0;
        while ((exp_q.size() > left || gw_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_budget_expired", 32'(n >= budget), 0);
    endtask

    task automatic do_restart();
        restart  = 1'b1;
        last_cyc = cyc + 1;
        @(negedge clk);
        #1;
        restart = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard monitor: compare every presented event.
    always @(negedge clk) begin
        if (rst_n && tick) begin
            tick_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 1, 0);
            end else begin
                me = exp_q.pop_front();
                if (me.rnd) begin
                    check("rnd_step_range", 32'(step <= me.step), 1);
                    check("rnd_trig", trig, pat_at(pattern, int'(step)));
                    check("rnd_gate", gate, 0);
                    hist[step]++;
                end else begin
                    check("step", step, me.step);
                    check("trig", trig, me.trig);
                    check("gate_at_tick", gate, me.gate);
                end
                if (me.gap != 0) check("tick_gap", cyc - last_cyc, me.gap);
                last_cyc = cyc;
            end
        end
    end

    // Ch0 gate high-time measurement.
    always @(negedge clk) begin
        if (gw_en) begin
            if (gate[0]) begin
                gw_run++;
            end else if (gw_run != 0) begin
                if (gw_q.size() == 0) check("gate_width_unexpected", gw_run, 0);
                else                  check("gate_width", gw_run, gw_q.pop_front());
                gw_run = 0;
            end
        end
    end

    // Legato: count cycles in which ch0 gate is low while armed.
    always @(negedge clk) begin
        if (leg_en && !gate[0]) leg_low++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) hist[i] = 0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        restart  = 1'b0;
        div      = 4;
        len      = 3;
        mode     = 2'b00;
        gate_len = 2;
        pattern  = {16'hFFFF, 16'h0000, 16'h000A, 16'h0005};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_tick", tick, 0);
        check("reset_step", step, 0);
        check("reset_trig", trig, 0);
        check("reset_gate", gate, 0);

        // Forward: div 4, len 3, ch0 pattern 0101, gate 2 cycles
        ena = 1'b1;
        gw_en = 1;
        gw_run = 0;
        rst_n = 1'b1;
        last_cyc = cyc;
        push_step(0, 4); push_step(1, 4); push_step(2, 4); push_step(3, 4); push_step(0, 4);
        gw_q.push_back(2); gw_q.push_back(2); gw_q.push_back(2);
        wait_q(0, 100);
        ena = 1'b0;
        gw_en = 0;

        // Ping-pong, len 3, div 3
        mode = 2'b10;
        div  = 3;
        ena  = 1'b1;
        do_restart();
        push_step(0, 3); push_step(1, 3); push_step(2, 3); push_step(3, 3);
        push_step(2, 3); push_step(1, 3); push_step(0, 3); push_step(1, 3);
        wait_q(0, 100);
        ena = 1'b0;

        // Ping-pong with len 0 holds at 0
        len = 0;
        ena = 1'b1;
        do_restart();
        push_step(0, 3); push_step(0, 3); push_step(0, 3); push_step(0, 3);
        wait_q(0, 100);
        ena = 1'b0;

        // Reverse, len 7 down to 6, then shrink len to 3
        mode = 2'b01;
        len  = 7;
        div  = 5;
        ena  = 1'b1;
        do_restart();
        push_step(0, 5); push_step(7, 5); push_step(6, 5);
        wait_q(0, 100);
        len = 3;
        push_step(3, 5); push_step(2, 5); push_step(1, 5); push_step(0, 5); push_step(3, 5);
        wait_q(0, 100);
        ena = 1'b0;

        // Legato with all pattern bits set, then ena low for 5 cycles
        mode     = 2'b00;
        len      = 3;
        div      = 4;
        gate_len = 10;
        pattern  = '1;
        ena      = 1'b1;
        do_restart();
        push_step(0, 4); push_step(1, 4); push_step(2, 4); push_step(3, 4);
        wait_q(3, 50);
        leg_low = 0;
        leg_en  = 1;
        wait_q(0, 100);
        ena = 1'b0;
        saved_ticks = tick_seen;
        repeat (5) @(negedge clk);
        #1;
        check("ena_low_step_hold", step, 3);
        check("ena_low_gate_hold", gate, 4'hF);
        check("ena_low_no_tick", tick_seen - saved_ticks, 0);
        push_step(0, 0); push_step(1, 4);
        ena = 1'b1;
        wait_q(0, 100);
        check("legato_gate_low_cycles", leg_low, 0);
        leg_en = 0;

        // Asynchronous reset mid-step clears outputs without a clock edge
        rst_n = 1'b0;
        #1;
        check("async_rst_step", step, 0);
        check("async_rst_gate", gate, 0);
        check("async_rst_trig", trig, 0);
        check("async_rst_tick", tick, 0);

        // Restart coinciding with a step event
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        last_cyc = cyc;
        push_step(0, 4); push_step(1, 4);
        wait_q(0, 100);
        repeat (3) @(negedge clk);
        #1;
        restart  = 1'b1;
        last_cyc = cyc + 1;
        @(negedge clk);
        #1;
        check("restart_no_tick", tick, 0);
        check("restart_gate_clear", gate, 0);
        check("restart_trig_clear", trig, 0);
        check("restart_step_hold", step, 1);
        restart = 1'b0;
        push_step(0, 4);
        wait_q(0, 100);
        ena = 1'b0;

        // Mode 11 with len 5, div 0 (treated as 1), gate_len 0
        mode     = 2'b11;
        len      = 5;
        div      = 0;
        gate_len = 0;
        pattern  = {16'hFFFF, 16'h0000, 16'h000A, 16'h0005};
        ena      = 1'b1;
        do_restart();
`ifdef BITSEQ_MULTI_RANDOM_EN
        for (int i = 0; i < 1000; i++) push_rnd(5);
`else
        for (int i = 0; i < 1000; i++) push_step(i % 6, 1);
`endif
        wait_q(0, 3000);
        ena = 1'b0;
`ifdef BITSEQ_MULTI_RANDOM_EN
        for (int v = 0; v < 6; v++) check($sformatf("rnd_value_%0d_seen", v), 32'(hist[v] > 0), 1);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bitseq_multi.md
# bitseq_multi

Multi-channel, parametrised step sequencer generalising the single-channel bit sequencer: a shared clock divider produces step ticks, and one step pointer indexes a per-channel pattern word. Each channel emits a one-cycle trigger and a programmable-width gate. Step direction is selectable (forward, reverse, ping-pong, random). The block sits between the control registers (pattern, length, rate) and the voice/envelope blocks that consume gates and triggers.

## Interface
- `CHANNELS`, default 4: number of output channels, ≥1.
- `STEPS`, default 16: pattern depth, a power of two, ≥2. `SW = $clog2(STEPS)`.
- `DIV_W`, default 24: width of the divider and gate counters.

Ports:
- `clk` in 1: system clock; everything runs on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: run enable; when low, all state freezes.
- `restart` in 1: synchronous restart pulse.
- `div` in DIV_W: step period in `clk` cycles; 0 is treated as 1.
- `len` in SW: last active step index; active steps are 0..`len`.
- `mode` in 2: 00 forward, 01 reverse, 10 ping-pong, 11 random.
- `gate_len` in DIV_W: gate high time in `clk` cycles.
- `pattern` in CHANNELS*STEPS: bit `ch*STEPS+s` enables step `s` on channel `ch`.
- `tick` out 1: one-cycle pulse on each step advance.
- `step` out SW: current step index.
- `trig` out CHANNELS: one-cycle pulse per channel on an enabled step.
- `gate` out CHANNELS: per-channel gate.

## Operation
- Reset values: `tick`=0, `step`=0, `trig`=0, `gate`=0, divider counter=0, gate counter=0, ping-pong direction=up, `primed`=1, LFSR=16'hACE1.
- Divider: the counter runs 0..`div`-1 while `ena`=1. On the edge where the counter equals `div`-1, the counter returns to 0 and a step event occurs.
- Step event:
  - If `primed`=1, the next step is 0 and `primed` clears.
  - Otherwise the next step follows `mode`:
    - Forward: `step`+1, wrapping from ≥`len` to 0.
    - Reverse: `step`-1, wrapping from 0 to `len`; if `step`>`len`, go to `len`.
    - Ping-pong: bounces between 0 and `len` without repeating endpoints. Direction flips when the next step would pass an endpoint. `len`=0 holds at 0. If `step`>`len`, go to 0 with direction up.
    - Random: take candidate c = LFSR[SW-1:0] & m, where m is the all-ones mask of width = bit length of `len`. If c>`len`, use c-(`len`+1).
- On a step event, on the same edge:
  - `step` loads the next step.
  - `tick`=1.
  - `trig[ch]` = pattern bit of the new step.
  - `gate[ch]` = pattern bit AND (`gate_len`≠0).
  - The gate counter loads 1.
- Between events the gate counter increments, saturating at `gate_len`. All gates clear on the edge where the counter reaches `gate_len`.
- If `gate_len` ≥ `div`, gates are never cleared by the counter; consecutive enabled steps therefore produce a continuous gate (legato).
- LFSR: polynomial x^16+x^14+x^13+x^11+1, advances every `clk` cycle regardless of `ena`.
- `ena`=0:
  - Divider, gate counter, `step`, and `gate` hold.
  - `tick` and `trig` are 0.
- `restart`=1 (synchronous, while `ena` is either value):
  - Divider=0, gate counter=0, `gate`=0, `trig`=0, `tick`=0, direction=up, `primed`=1.
  - `step` holds.
  - Restart wins over a simultaneous step event.
- `pattern`, `len`, `mode`, and `gate_len` are sampled live; changes take effect at the next step event or gate-counter compare.

## Timing
- `tick`, `trig`, `step`, and `gate` are all registered and change on the same edge as the step event.
- First event after reset or restart: occurs `div` cycles later (counting from 0) and plays step 0.
- Event spacing: exactly `max(div,1)` cycles. With `div`≤1, an event occurs every cycle and `tick` stays high continuously.
- Gate width: exactly `gate_len` cycles when `gate_len` < `div`.
- Asserting `rst_n` mid-step clears all outputs immediately, without waiting for a clock edge.

## Configuration
- `BITSEQ_MULTI_RANDOM_EN` defined: the LFSR and random mode are compiled in.
- Not defined: no LFSR is instantiated, and `mode`=11 behaves as forward.

## Test plan
- Forward: `div`=4, `len`=3, `pattern[3:0]`=4'b0101 on ch0, `gate_len`=2.
  - Required: `tick` every 4 cycles; `step` 0,1,2,3,0.
  - Required: ch0 `trig` on steps 0 and 2; `gate` high exactly 2 cycles on those steps.
- Ping-pong: `len`=3.
  - Required: `step` 0,1,2,3,2,1,0,1.
  - With `len`=0: `step` stays at 0.
- Reverse with `len` shrink: `len`=7, `step`=6; set `len`=3.
  - Required: next `step`=3, then 2, 1, 0, 3.
- Legato and `ena`: `gate_len`=10, `div`=4, all pattern bits set.
  - Required: ch0 `gate` continuously high.
  - Drop `ena` for 5 cycles: `step` and `gate` hold, no `tick`.
- Restart coinciding with a step event.
  - Required: no `tick`, gates clear, and the next event comes `div` cycles later with `step`=0.
- Random (`BITSEQ_MULTI_RANDOM_EN`): `len`=5, 1000 events.
  - Required: every `step` ≤5, and each value 0..5 appears at least once.
  - Without the macro: the sequence equals forward mode.
